// File: rtl/instr_fetcher.sv
// Instruction-fetch front end between the PC stage and instruction memory.
// It latches a PC on pc_en and issues a single read request. It waits for
// the memory to accept the request and for the data to return, then loads
// the returned word into the instruction register. Only one fetch is in
// flight at a time. stall holds the PC/pipeline while a fetch is outstanding.
//
// Ports:
//   clk       in   1     clock, all state on rising edge
//   rst       in   1     synchronous reset, active-high
//   mem_rdy   in   1     memory accepts the request this cycle
//   valid     in   1     rdata carries the requested word this cycle
//   pc_en     in   1     new PC on addr_in; start a fetch
//   addr_in   in   bits  PC from PC stage
//   rdata     in   bits  instruction word from memory
//   addr_out  out  bits  registered fetch address to memory
//   ir        out  bits  instruction register
//   stall     out  1     fetch outstanding (decoded from state + valid)
//   proc_req  out  1     read request to memory (decoded from state)
//
// Optional build macro IR_NOP_INJECT_EN: while stall is high, the ir output
// shows a NOP (32'h0000_0013) instead of the register contents. The register
// itself is unaffected.

module instr_fetcher #(
   parameter int unsigned bits = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_rdy,
   input  logic            valid,
   input  logic            pc_en,
   input  logic [bits-1:0] addr_in,
   input  logic [bits-1:0] rdata,
   output logic [bits-1:0] addr_out,
   output logic [bits-1:0] ir,
   output logic            stall,
   output logic            proc_req
);

   localparam logic [bits-1:0] NOP = bits'(32'h0000_0013);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10
   } state_t;

   state_t          state, state_next;
   logic [bits-1:0] addr_q, addr_next;
   logic [bits-1:0] ir_q, ir_next;

   // State, fetch address and instruction register
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         addr_q <= '0;
         ir_q   <= NOP;
      end else begin
         state  <= state_next;
         addr_q <= addr_next;
         ir_q   <= ir_next;
      end
   end

   // Next-state, register updates and request/stall decode
   always_comb begin
      state_next = state;
      addr_next  = addr_q;
      ir_next    = ir_q;
      proc_req   = 1'b0;
      stall      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pc_en) begin
               addr_next  = addr_in;
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            proc_req = 1'b1;
            stall    = 1'b1;
            if (mem_rdy) state_next = ST_WAIT;
         end
         ST_WAIT: begin
            stall = ~valid;
            // rdata is only sampled here, so X outside WAIT&valid never reaches ir
            if (valid) begin
               ir_next = rdata;
               if (pc_en) begin
                  addr_next  = addr_in;
                  state_next = ST_REQ;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign addr_out = addr_q;

`ifdef IR_NOP_INJECT_EN
   // Present a NOP downstream while the fetch is outstanding
   assign ir = stall ? NOP : ir_q;
`else
   assign ir = ir_q;
`endif

endmodule

// File: tb/tb_instr_fetcher.sv
module tb_instr_fetcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_rdy;
   logic        valid;
   logic        pc_en;
   logic [31:0] addr_in;
   logic [31:0] rdata;
   logic [31:0] addr_out;
   logic [31:0] ir;
   logic        stall;
   logic        proc_req;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   instr_fetcher #(.bits(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_rdy  (mem_rdy),
      .valid    (valid),
      .pc_en    (pc_en),
      .addr_in  (addr_in),
      .rdata    (rdata),
      .addr_out (addr_out),
      .ir       (ir),
      .stall    (stall),
      .proc_req (proc_req)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ir expected while stall=1 depends on the NOP-inject build option
   function automatic logic [31:0] ir_stalled(input logic [31:0] held);
`ifdef IR_NOP_INJECT_EN
      return NOP;
`else
      return held;
`endif
   endfunction

   initial begin
      rst = 1'b1; mem_rdy = 1'b0; valid = 1'b0; pc_en = 1'b0;
      addr_in = '0; rdata = '0;
      tick();
      check("rst_addr_out", addr_out, 32'h0);
      check("rst_ir", ir, NOP);
      check("rst_proc_req", 32'(proc_req), 32'h0);
      check("rst_stall", 32'(stall), 32'h0);
      rst = 1'b0;

      // Start fetch of 0xBEEFBEEF, memory not ready for two cycles
      pc_en = 1'b1; addr_in = 32'hBEEF_BEEF;
      #1;
      check("idle_proc_req", 32'(proc_req), 32'h0);
      check("idle_stall", 32'(stall), 32'h0);
      tick();
      addr_in = 32'h0BAD_0BAD;  // pc_en still high: must be ignored in REQ
      #1;
      check("req1_proc_req", 32'(proc_req), 32'h1);
      check("req1_stall", 32'(stall), 32'h1);
      check("req1_addr_out", addr_out, 32'hBEEF_BEEF);
      check("req1_ir", ir, ir_stalled(NOP));
      tick();
      pc_en = 1'b0;
      check("req2_proc_req", 32'(proc_req), 32'h1);
      check("req2_addr_out", addr_out, 32'hBEEF_BEEF);
      mem_rdy = 1'b1;
      tick();
      mem_rdy = 1'b0;
      #1;
      check("wait_proc_req", 32'(proc_req), 32'h0);
      check("wait_stall", 32'(stall), 32'h1);
      rdata = 'x;  // X outside valid must not reach ir
      tick();
      check("wait_hold_stall", 32'(stall), 32'h1);
      check("wait_hold_ir", ir, ir_stalled(NOP));

      // Data returns, no follow-on PC
      valid = 1'b1; rdata = 32'hCAFE_CAFE;
      #1;
      check("ret_stall_same_cycle", 32'(stall), 32'h0);
      tick();
      valid = 1'b0; rdata = 'x;
      #1;
      check("ret_ir", ir, 32'hCAFE_CAFE);
      check("ret_idle_proc_req", 32'(proc_req), 32'h0);
      check("ret_idle_stall", 32'(stall), 32'h0);

      // Second fetch, then back-to-back with a third
      pc_en = 1'b1; addr_in = 32'h1111_0000;
      tick();
      pc_en = 1'b0; mem_rdy = 1'b1;
      tick();
      mem_rdy = 1'b0;
      #1;
      check("wait2_ir_held", ir, ir_stalled(32'hCAFE_CAFE));
      valid = 1'b1; rdata = 32'hDEAD_BEEF; pc_en = 1'b1; addr_in = 32'hCACC_ACAC;
      #1;
      check("b2b_stall_same_cycle", 32'(stall), 32'h0);
      tick();
      valid = 1'b0; pc_en = 1'b0; rdata = 'x; addr_in = '0;
      #1;
      check("b2b_proc_req", 32'(proc_req), 32'h1);
      check("b2b_addr_out", addr_out, 32'hCACC_ACAC);
      check("b2b_ir", ir, ir_stalled(32'hDEAD_BEEF));
      mem_rdy = 1'b1;
      tick();
      mem_rdy = 1'b0;
      valid = 1'b1; rdata = 32'hFAFA_FAFA;
      tick();
      valid = 1'b0; rdata = 'x;
      #1;
      check("third_ir", ir, 32'hFAFA_FAFA);
      check("third_addr_out", addr_out, 32'hCACC_ACAC);
      check("third_idle_proc_req", 32'(proc_req), 32'h0);

      // valid in IDLE is ignored
      valid = 1'b1; rdata = 32'h1234_5678;
      tick();
      valid = 1'b0; rdata = 'x;
      #1;
      check("idle_valid_ir", ir, 32'hFAFA_FAFA);
      check("idle_valid_proc_req", 32'(proc_req), 32'h0);

      // Reset during REQ drops the request
      pc_en = 1'b1; addr_in = 32'h55AA_55AA;
      tick();
      pc_en = 1'b0;
      #1;
      check("pre_rst_proc_req", 32'(proc_req), 32'h1);
      check("pre_rst_addr_out", addr_out, 32'h55AA_55AA);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("midrst_proc_req", 32'(proc_req), 32'h0);
      check("midrst_stall", 32'(stall), 32'h0);
      check("midrst_addr_out", addr_out, 32'h0);
      check("midrst_ir", ir, NOP);
      tick();
      check("post_rst_idle", 32'(proc_req), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
